// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus carry flop, LSB first.
// Latency: WIDTH cycles from the accept edge to valid_o; one result per WIDTH+1 cycles back to back.
// Backpressure: ready_o is low while a sum is in progress, and start_i is ignored during that time.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             cy_q;
  logic [CW-1:0]    cnt_q;
  logic             last_bit;
  logic             s_bit;
  logic             cy_next;

  // Full-adder cell on the current LSBs and the carry flop
  assign s_bit    = a_sh[0] ^ b_sh[0] ^ cy_q;
  assign cy_next  = (a_sh[0] & b_sh[0]) | (a_sh[0] & cy_q) | (b_sh[0] & cy_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // State register; reset overrides any pending start
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs, decoded from state only
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ready_o = 1'b1;
        valid_o = 1'b1;
        if (start_i) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand load, bit-serial shifting and result capture on the final bit
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      a_sh       <= '0;
      b_sh       <= '0;
      s_sh       <= '0;
      cy_q       <= 1'b0;
      cnt_q      <= '0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else if (accept) begin
      a_sh  <= a_i;
      b_sh  <= b_i;
      s_sh  <= '0;
      cy_q  <= c_i;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= {s_bit, s_sh[WIDTH-1:1]};
      cy_q  <= cy_next;
      cnt_q <= cnt_q + 1'b1;
      if (last_bit) begin
        // cy_q here is the carry into the MSB, cy_next the carry out of it
        sum_o      <= {s_bit, s_sh[WIDTH-1:1]};
        carry_o    <= cy_next;
        overflow_o <= cy_q ^ cy_next;
      end
    end
  end

endmodule
